// File: rtl/cpu_multicycle.sv
// Multicycle accumulator-style CPU: 4 registers, ZF/SF/CF flags, a unified
// program/data memory of IW = DW+6 bit words and a FETCH/EXEC/MEM/HALT sequencer.
module cpu_multicycle #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_addr,
    input  logic [DW+5:0]   prog_data,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   pc,
    output logic [DW+5:0]   ir,
    output logic            halted,
    output logic [DW-1:0]   reg0,
    output logic [DW-1:0]   reg1,
    output logic [DW-1:0]   reg2,
    output logic [DW-1:0]   reg3
);
    localparam int IW    = DW + 6;
    localparam int DEPTH = 2 ** AW;

    localparam logic [3:0] OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4, OP_ADDI = 4'h5, OP_MOVI = 4'h6, OP_LD = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8, OP_JMP = 4'h9, OP_JZ = 4'hA, OP_JC = 4'hB;
    localparam logic [3:0] OP_JN   = 4'hC, OP_IN = 4'hD, OP_OUT = 4'hE, OP_HALT = 4'hF;

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   mem [DEPTH];
    logic [DW-1:0]   regs [4];
    logic            zf, sf, cf;

    logic [3:0]      op;
    logic [1:0]      rd, rs;
    logic [DW-1:0]   imm, rd_val, rs_val, ld_data;
    logic [AW-1:0]   addr;

    logic [DW:0]     alu_full;
    logic            ir_load, pc_load, reg_we, flag_we, mem_st;
    logic [AW-1:0]   pc_nxt;
    logic [DW-1:0]   reg_wdata;

    assign op      = ir[IW-1:IW-4];
    assign rd      = ir[IW-5:IW-6];
    assign rs      = ir[DW-1:DW-2];
    assign imm     = ir[DW-1:0];
    assign addr    = ir[AW-1:0];
    assign rd_val  = regs[rd];
    assign rs_val  = regs[rs];
    assign ld_data = mem[addr][DW-1:0];

    assign out_data = rd_val;
    assign halted   = (state == HALT);
    assign reg0 = regs[0];
    assign reg1 = regs[1];
    assign reg2 = regs[2];
    assign reg3 = regs[3];

    // SUB is rd + ~rs + 1 so the carry-out doubles as a "no borrow" flag.
    always_comb begin
        alu_full = {1'b0, rd_val} + {1'b0, imm};
        case (op)
            OP_ADD: alu_full = {1'b0, rd_val} + {1'b0, rs_val};
            OP_SUB: alu_full = {1'b0, rd_val} + {1'b0, ~rs_val} + {{DW{1'b0}}, 1'b1};
            OP_AND: alu_full = {1'b0, rd_val & rs_val};
            OP_OR:  alu_full = {1'b0, rd_val | rs_val};
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        ir_load   = 1'b0;
        pc_load   = 1'b0;
        pc_nxt    = pc + {{(AW-1){1'b0}}, 1'b1};
        reg_we    = 1'b0;
        reg_wdata = alu_full[DW-1:0];
        flag_we   = 1'b0;
        mem_st    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (run) begin
            case (state)
                FETCH: begin
                    ir_load   = 1'b1;
                    state_nxt = EXEC;
                end
                EXEC: begin
                    state_nxt = FETCH;
                    pc_load   = 1'b1;
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                            reg_we  = 1'b1;
                            flag_we = 1'b1;
                        end
                        OP_MOVI: begin
                            reg_we    = 1'b1;
                            reg_wdata = imm;
                        end
                        OP_LD, OP_ST: begin
                            pc_load   = 1'b0;
                            state_nxt = MEM;
                        end
                        OP_JMP: pc_nxt = addr;
                        OP_JZ:  if (zf) pc_nxt = addr;
                        OP_JC:  if (cf) pc_nxt = addr;
                        OP_JN:  if (sf) pc_nxt = addr;
                        OP_IN: begin
                            in_ready  = 1'b1;
                            reg_wdata = in_data;
                            reg_we    = in_valid;
                            pc_load   = in_valid;
                            state_nxt = in_valid ? FETCH : EXEC;
                        end
                        OP_OUT: begin
                            out_valid = 1'b1;
                            pc_load   = out_ready;
                            state_nxt = out_ready ? FETCH : EXEC;
                        end
                        OP_HALT: state_nxt = HALT;
                        default: ;
                    endcase
                end
                MEM: begin
                    state_nxt = FETCH;
                    pc_load   = 1'b1;
                    if (op == OP_LD) begin
                        reg_we    = 1'b1;
                        reg_wdata = ld_data;
                    end else begin
                        mem_st = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
            zf    <= 1'b0;
            sf    <= 1'b0;
            cf    <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            if (ir_load) ir <= mem[pc];
            if (pc_load) pc <= pc_nxt;
            if (reg_we) regs[rd] <= reg_wdata;
            if (flag_we) begin
                zf <= (alu_full[DW-1:0] == '0);
                sf <= alu_full[DW-1];
                cf <= alu_full[DW];
            end
        end
    end

    // An internal store wins over an external program write in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_st) begin
            mem[addr] <= {{(IW-DW){1'b0}}, rd_val};
        end else if (prog_we && (!run || halted)) begin
            mem[prog_addr] <= prog_data;
        end
    end
endmodule
